mem_lsu: RTL

Memory-access stage, directly downstream of the exe→mem pipeline register and upstream of the mem→wb register. Non-memory results pass straight through. Loads and stores (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) become a single word-aligned data-bus transaction under a small FSM. The stage stalls the pipeline until the transaction finishes, then presents the aligned, extended load result to writeback.

---
 rtl/mem_lsu.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage. Non-memory results pass through; RV32I loads/stores become one
// word-aligned data-bus transaction under a four-state FSM that stalls the pipeline until it completes.
module mem_lsu #(
   parameter int DATA_WIDTH  = 32,
   parameter int RADDR_WIDTH = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [31:0]            inst_i,
   input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
   input  logic                   reg_we_i,
   input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
   input  logic [DATA_WIDTH-1:0]  mem_wdata_i,
   output logic [RADDR_WIDTH-1:0] reg_waddr_o,
   output logic                   reg_we_o,
   output logic [DATA_WIDTH-1:0]  reg_wdata_o,
   output logic                   stall_o,
   output logic                   misalign_o,
   output logic                   dbus_req_o,
   output logic                   dbus_we_o,
   output logic [DATA_WIDTH-1:0]  dbus_addr_o,
   output logic [3:0]             dbus_be_o,
   output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
   input  logic                   dbus_gnt_i,
   input  logic                   dbus_rvalid_i,
   input  logic [DATA_WIDTH-1:0]  dbus_rdata_i
);
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
   state_e state_q, state_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, shifted, ext;
   logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [3:0] be_q, be_d;
   logic [2:0] f3_q, f3_d, f3;
   logic [1:0] off_q, off_d, off;
   logic we_q, we_d, load_q, load_d;
   logic ls_op, is_ld, is_st, mis, idle, go, unused;

   assign f3 = inst_i[14:12];
   assign off = reg_wdata_i[1:0];
   assign ls_op = inst_i[6:0] == OP_LOAD || inst_i[6:0] == OP_STORE;
   assign is_ld = inst_i[6:0] == OP_LOAD && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   assign is_st = inst_i[6:0] == OP_STORE && (f3 inside {3'b000, 3'b001, 3'b010});
   assign mis = (is_ld || is_st) && (f3[1:0] == 2'b01 ? off[0] : (f3[1:0] == 2'b10 && off != 2'b00));
   assign idle = state_q == IDLE;
   assign go = idle && (is_ld || is_st) && !mis;
   assign unused = ^{inst_i[31:15], inst_i[11:7]};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = go ? REQ : IDLE;
         REQ:     state_d = dbus_gnt_i ? RESP : REQ;
         RESP:    state_d = dbus_rvalid_i ? DONE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         waddr_q <= '0;
         be_q    <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         we_q    <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         waddr_q <= waddr_d;
         be_q    <= be_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         we_q    <= we_d;
         load_q  <= load_d;
      end
   end

   // Load extraction works on the latched byte offset and size, not on the live instruction.
   always_comb begin
      shifted = dbus_rdata_i >> {off_q, 3'b000};
      ext = f3_q == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
            f3_q == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]} :
            f3_q == 3'b100 ? {24'b0, shifted[7:0]} :
            f3_q == 3'b101 ? {16'b0, shifted[15:0]} : shifted;
   end

   always_comb begin
      addr_d  = go ? {reg_wdata_i[DATA_WIDTH-1:2], 2'b00} : addr_q;
      off_d   = go ? off : off_q;
      f3_d    = go ? f3 : f3_q;
      waddr_d = go ? reg_waddr_i : waddr_q;
      load_d  = go ? is_ld : load_q;
      we_d    = go ? is_st : we_q;
      be_d    = !go ? be_q :
                is_ld ? 4'b1111 :
                f3[1:0] == 2'b00 ? 4'b0001 << off :
                f3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
      wdata_d = !go ? wdata_q :
                f3[1:0] == 2'b00 ? {4{mem_wdata_i[7:0]}} :
                f3[1:0] == 2'b01 ? {2{mem_wdata_i[15:0]}} : mem_wdata_i;
      data_d  = state_q == RESP && dbus_rvalid_i ? ext : data_q;
   end

   // Reset gates the combinational pass-through so every output reads zero while rst_n_i is low.
   always_comb begin
      stall_o      = rst_n_i && (go || state_q == REQ || state_q == RESP);
      misalign_o   = rst_n_i && idle && mis;
      reg_we_o     = rst_n_i && (state_q == DONE ? load_q : idle && reg_we_i && !ls_op);
      reg_waddr_o  = !rst_n_i ? '0 : state_q == DONE ? waddr_q : reg_waddr_i;
      reg_wdata_o  = !rst_n_i ? '0 : state_q == DONE ? data_q : reg_wdata_i;
      dbus_req_o   = state_q == REQ;
      dbus_we_o    = we_q;
      dbus_addr_o  = addr_q;
      dbus_be_o    = be_q;
      dbus_wdata_o = wdata_q;
   end
endmodule
